// File: rtl/slow_memory.sv
`default_nettype none
// ============================================================================
//  Module      : slow_memory
//  Description : 128-bit-wide single-port memory model with fixed access
//                latency. One outstanding request at a time, completed by a
//                one-cycle mem_ready strobe. Storage lives in the array 'mem'
//                so benches can preload it hierarchically.
//  Options     : SLOW_MEMORY_PROTOCOL_CHECK_EN - when defined, builds a sticky
//                checker that flags master-side handshake violations on
//                protocol_err; otherwise protocol_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module slow_memory #(
    parameter int MEM_NUM = 256,   // number of 128-bit words, power of two
    parameter int LATENCY = 5      // sample edge to mem_ready, 1..255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         protocol_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int             IDX_W    = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
    localparam int             CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Storage (never reset: contents survive rst)
    // ------------------------------------------------------------------------
    logic [127:0] mem [0:MEM_NUM-1];

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               op_wr_q, op_wr_d;   // 1 = write, 0 = read
    logic [27:0]        addr_q,  addr_d;    // full address kept for the checker
    logic [127:0]       wdata_q, wdata_d;
    logic [127:0]       rdata_q, rdata_d;
    logic               ready_q, ready_d;

    // Memory write port, driven from the next-state logic
    logic               w_mem_we;
    logic [IDX_W-1:0]   w_mem_widx;
    logic [127:0]       w_mem_wval;

    logic               w_req;
    logic [IDX_W-1:0]   w_in_idx;
    logic [IDX_W-1:0]   w_lat_idx;

    assign w_req     = mem_read | mem_write;
    assign w_in_idx  = mem_addr[IDX_W-1:0];   // address modulo MEM_NUM
    assign w_lat_idx = addr_q[IDX_W-1:0];

    // Next-state logic: request capture, latency countdown, completion.
    // The write and the read-data capture both happen on the edge that
    // enters RESP, so a read always sees every earlier completed write.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = '0;
        ready_d    = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_widx = w_lat_idx;
        w_mem_wval = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    // Write wins when both request lines are high.
                    op_wr_d = mem_write;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    if (LATENCY <= 1) begin
                        // Single-cycle latency completes straight from the
                        // sampled inputs; there is no WAIT phase.
                        state_d = ST_RESP;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        if (mem_write) begin
                            w_mem_we   = 1'b1;
                            w_mem_widx = w_in_idx;
                            w_mem_wval = mem_wdata;
                        end else begin
                            rdata_d = mem[w_in_idx];
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end

            ST_WAIT: begin
                // Inputs are ignored here; only latched values are used.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    if (op_wr_q) begin
                        w_mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[w_lat_idx];
                    end
                end
            end

            ST_RESP: begin
                // The edge leaving RESP never samples a request, which
                // enforces a one-cycle gap between transactions.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM and registered outputs; reset clears them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Storage write; suppressed while rst is high so an aborted write
    // never lands in the array.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            mem[w_mem_widx] <= w_mem_wval;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;

`ifdef SLOW_MEMORY_PROTOCOL_CHECK_EN
    // ------------------------------------------------------------------------
    // Protocol checker
    // ------------------------------------------------------------------------
    logic w_perr_set;
    logic perr_q;

    // Violation detection: a WAIT-phase request must stay asserted with the
    // same address and operation; an IDLE sample must not carry both ops.
    always_comb begin
        w_perr_set = 1'b0;
        case (state_q)
            ST_WAIT: w_perr_set = !w_req
                                  || (mem_addr  != addr_q)
                                  || (mem_write != op_wr_q);
            ST_IDLE: w_perr_set = mem_read & mem_write;
            default: w_perr_set = 1'b0;
        endcase
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (w_perr_set) begin
            perr_q <= 1'b1;
        end
    end

    assign protocol_err = perr_q;
`else
    // Upper address bits only matter to the checker; fold them into a sink.
    logic w_unused_addr;
    assign w_unused_addr = ^addr_q[27:IDX_W];

    assign protocol_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slow_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slow_memory
//  Description : Scoreboard bench for slow_memory. The driver pushes the
//                expected read data for each request; a monitor pops and
//                compares whenever mem_ready is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slow_memory;

    localparam int LAT  = 5;
    localparam int MEMN = 256;
`ifdef SLOW_MEMORY_PROTOCOL_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    localparam logic [127:0] D_A5 = {16{8'hA5}};
    localparam logic [127:0] D_07 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] D_02 = 128'h2222_0000_1111_0000_DEAD_BEEF_0000_0002;
    localparam logic [127:0] D_09 = 128'h1;
    localparam logic [127:0] D_BAD = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    localparam logic [127:0] D_0B = 128'hB0B0_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [127:0] D_0A = 128'h0A0A_0A0A_F00D_CAFE_0A0A_0A0A_1234_5678;
    localparam logic [127:0] D_04 = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
    localparam logic [127:0] D_05 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         protocol_err;

    int errors = 0;
    int checks = 0;
    logic [127:0] exp_q [$];

    slow_memory #(
        .MEM_NUM (MEMN),
        .LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per mem_ready cycle; rdata must be 0 otherwise.
    always @(negedge clk) begin : monitor
        logic [127:0] e;
        if (mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready with empty scoreboard, expected none");
            end else begin
                e = exp_q.pop_front();
                check("rdata", mem_rdata, e);
            end
        end else begin
            check("rdata_idle", mem_rdata, '0);
        end
    end

    // One request: hold it until mem_ready, measure latency from the sample edge.
    // gap=0 leaves the request asserted over the edge that leaves RESP.
    // bump=1 moves the address by one in the middle of WAIT.
    task automatic txn(input logic rd, input logic wr, input logic [27:0] a,
                       input logic [127:0] d, input logic [127:0] exp,
                       input int exp_lat, input bit gap, input bit bump);
        int n;
        bit got;
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        exp_q.push_back(exp);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_ready === 1'b1) got = 1'b1;
            else if (bump && n == 2) mem_addr = a + 28'd1;
        end
        check("latency", 128'(n), 128'(exp_lat));
        if (gap) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            @(posedge clk);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", 128'(mem_ready), 128'(0));
        check("reset_rdata", mem_rdata, '0);
        check("reset_perr",  128'(protocol_err), 128'(0));
        rst = 1'b0;

        // Basic write/read with the nominal latency.
        txn(1'b0, 1'b1, 28'd3, D_A5, '0, LAT, 1'b1, 1'b0);
        txn(1'b1, 1'b0, 28'd3, '0, D_A5, LAT, 1'b1, 1'b0);
        txn(1'b0, 1'b1, 28'd7, D_07, '0, LAT, 1'b1, 1'b0);
        txn(1'b1, 1'b0, 28'd7, '0, D_07, LAT, 1'b1, 1'b0);

        // Address wraps modulo MEM_NUM.
        txn(1'b0, 1'b1, 28'd2, D_02, '0, LAT, 1'b1, 1'b0);
        txn(1'b1, 1'b0, 28'(MEMN + 2), '0, D_02, LAT, 1'b1, 1'b0);
        txn(1'b1, 1'b0, 28'hFFFFF02, '0, D_02, LAT, 1'b1, 1'b0);

        // Reset in the middle of a write aborts it.
        txn(1'b0, 1'b1, 28'd9, D_09, '0, LAT, 1'b1, 1'b0);
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 28'd9;
        mem_wdata = D_BAD;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ready", 128'(mem_ready), 128'(0));
        check("abort_rdata", mem_rdata, '0);
        check("abort_perr",  128'(protocol_err), 128'(0));
        mem_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        txn(1'b1, 1'b0, 28'd9, '0, D_09, LAT, 1'b1, 1'b0);

        // Request held over the RESP exit edge is not sampled there;
        // same-address read returns the freshest data.
        txn(1'b0, 1'b1, 28'd11, D_0B, '0, LAT, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 28'd11, '0, D_0B, LAT + 1, 1'b1, 1'b0);
        check("perr_clean", 128'(protocol_err), 128'(0));

        // Read and write together -> write.
        txn(1'b1, 1'b1, 28'd10, D_0A, '0, LAT, 1'b1, 1'b0);
        check("perr_both", 128'(protocol_err), 128'(PCHK));
        txn(1'b1, 1'b0, 28'd10, '0, D_0A, LAT, 1'b1, 1'b0);
        check("perr_sticky", 128'(protocol_err), 128'(PCHK));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("perr_reset", 128'(protocol_err), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Address changed mid-WAIT: latched address wins.
        txn(1'b0, 1'b1, 28'd4, D_04, '0, LAT, 1'b1, 1'b0);
        txn(1'b0, 1'b1, 28'd5, D_05, '0, LAT, 1'b1, 1'b0);
        check("perr_pre_bump", 128'(protocol_err), 128'(0));
        txn(1'b1, 1'b0, 28'd4, '0, D_04, LAT, 1'b1, 1'b1);
        check("perr_bump", 128'(protocol_err), 128'(PCHK));

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
